// File: rtl/instr_fetch_unit.sv
// Decoupled fetch front-end: loadable instruction memory, PC and a show-ahead prefetch FIFO.
// Define IFU_HALT_DETECT_EN to stop issuing after a word with opcode 4'hF is pushed.
module instr_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_we,
  input  logic [ADDR_W-1:0]      imem_waddr,
  input  logic [DATA_W-1:0]      imem_wdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic [ADDR_W-1:0]      fetch_pc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef IFU_HALT_DETECT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
`else
  typedef enum logic {RUN = 1'b0} state_t;
`endif

  state_t            state;

  logic [DATA_W-1:0] mem       [2**ADDR_W];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_pc;

  logic              push;
  logic              pop;
  logic              halt_push;
  logic              issue;
  logic [CW:0]       occ;

  // The occupancy test counts the read already in flight so a full FIFO never overflows.
  always_comb begin
    push = inflight;
    pop  = (count != '0) && instr_ready;
`ifdef IFU_HALT_DETECT_EN
    halt_push = push && (rd_data[DATA_W-1 -: 4] == 4'hF);
`else
    halt_push = 1'b0;
`endif
    occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue = !redirect_valid && (state == RUN) && !halt_push && (occ < (CW+1)'(DEPTH));
  end

  // Synchronous memory: a same-edge write and read of one address returns the old word.
  always_ff @(posedge clk) begin
    if (imem_we)
      mem[imem_waddr] <= imem_wdata;
    rd_data <= mem[fetch_pc];
    rd_pc   <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid && push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_pc[wr_ptr]   <= rd_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= redirect_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= issue;
      if (issue)
        fetch_pc <= fetch_pc + ADDR_W'(1);
`ifdef IFU_HALT_DETECT_EN
      if (halt_push)
        state <= HALT;
`endif
    end
  end

  always_comb begin
    instr_valid = (count != '0);
    instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
    fifo_count  = count;
`ifdef IFU_HALT_DETECT_EN
    halted      = (state == HALT);
`else
    halted      = 1'b0;
`endif
  end

endmodule
